// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and the flag bundle shared by the alu_mc files
package alu_pkg;
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_LSL   = 4'b0010;
  localparam logic [3:0] OP_LSR   = 4'b0011;
  localparam logic [3:0] OP_LSVL  = 4'b0100;
  localparam logic [3:0] OP_LSVR  = 4'b0101;
  localparam logic [3:0] OP_ASVR  = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_OR    = 4'b1000;
  localparam logic [3:0] OP_XOR   = 4'b1001;
  localparam logic [3:0] OP_XNOR  = 4'b1010;
  localparam logic [3:0] OP_SLT   = 4'b1011;
  localparam logic [3:0] OP_MULT  = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1101;
  localparam logic [3:0] OP_DIV   = 4'b1110;
  localparam logic [3:0] OP_DIVU  = 4'b1111;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
  typedef struct packed {
    logic ovf;
    logic ill;
    logic div0;
  } alu_flags_t;
endpackage

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative shift-add multiplier / restoring divider, one step per cycle
// Ports: clk, rst_n (async active-low); start pulse with is_div/is_signed and op_a/op_b;
// done pulses for one cycle with res_lo (product low / quotient), res_hi (product high /
// remainder) and ovf (signed most-negative / -1). Divide by zero must not be started.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WL = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          is_div,
  input  logic          is_signed,
  input  logic [WL-1:0] op_a,
  input  logic [WL-1:0] op_b,
  output logic          done,
  output logic [WL-1:0] res_lo,
  output logic [WL-1:0] res_hi,
  output logic          ovf
);
  localparam int CW = $clog2(WL + 1);
  logic busy_q, busy_d, div_q, div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WL-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [WL:0] shl, trial, madd;
  logic [2*WL-1:0] prod;
  logic a_neg, b_neg;
  assign a_neg = is_signed && op_a[WL-1];
  assign b_neg = is_signed && op_b[WL-1];
  // The engine works on magnitudes; signs are restored after the last step.
  always_comb begin
    shl = {hi_q, lo_q[WL-1]};
    trial = shl - {1'b0, m_q};
    madd = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    busy_d = busy_q;
    div_d = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    m_d = m_q;
    if (start) begin
      busy_d = 1'b1;
      div_d = is_div;
      neg_lo_d = a_neg ^ b_neg;
      neg_hi_d = is_div ? a_neg : a_neg ^ b_neg;
      ovf_d = is_div && is_signed && op_a == {1'b1, {(WL-1){1'b0}}} && &op_b;
      cnt_d = CW'(WL);
      hi_d = '0;
      lo_d = a_neg ? -op_a : op_a;
      m_d = b_neg ? -op_b : op_b;
    end else if (busy_q && cnt_q == '0) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      cnt_d = cnt_q - 1'b1;
      // trial[WL] is the borrow: set when the partial remainder is below the divisor
      hi_d = div_q ? (trial[WL] ? shl[WL-1:0] : trial[WL-1:0]) : madd[WL:1];
      lo_d = div_q ? {lo_q[WL-2:0], ~trial[WL]} : {madd[0], lo_q[WL-1:1]};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      m_q <= '0;
    end else begin
      busy_q <= busy_d;
      div_q <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      m_q <= m_d;
    end
  end
  assign prod = neg_lo_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign done = busy_q && cnt_q == '0;
  assign res_lo = div_q ? (neg_lo_q ? -lo_q : lo_q) : prod[WL-1:0];
  assign res_hi = div_q ? (neg_hi_q ? -hi_q : hi_q) : prod[2*WL-1:WL];
  assign ovf = ovf_q;
endmodule

// File: rtl/alu_mc.sv
// alu_mc: valid/ready multi-cycle execute ALU with registered results
// Ports: CLK, RST_N (async active-low); request IN_VALID/IN_READY with ALUSel, shamt,
// ALUIN1, ALUIN2; result OUT_VALID/OUT_READY with ALUOut, ALUOutHi, zero, OVF_F, ILL_F, DIV0_F.
// Define ALU_MULDIV_EN to build the iterative multiply/divide engine; otherwise
// opcodes 1100-1111 complete in one cycle as illegal and ALUOutHi stays 0.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WL  = 32,
  parameter int SHW = $clog2(WL)
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           IN_VALID,
  output logic           IN_READY,
  input  logic [3:0]     ALUSel,
  input  logic [SHW-1:0] shamt,
  input  logic [WL-1:0]  ALUIN1,
  input  logic [WL-1:0]  ALUIN2,
  output logic           OUT_VALID,
  input  logic           OUT_READY,
  output logic [WL-1:0]  ALUOut,
  output logic [WL-1:0]  ALUOutHi,
  output logic           zero,
  output logic           OVF_F,
  output logic           ILL_F,
  output logic           DIV0_F
);
  state_t state_q, state_d;
  logic [WL-1:0] lo_q, lo_d, hi_q, hi_d, sc_lo, sc_hi, sum, dif, md_lo, md_hi;
  logic zero_q, zero_d, accept, go_busy, ld_sc, ld_md, md_done, md_ovf;
  alu_flags_t flags_q, flags_d, sc_flags;
`ifdef ALU_MULDIV_EN
  logic is_div;
  assign is_div = ALUSel == OP_DIV || ALUSel == OP_DIVU;
  // Divide by zero is resolved immediately and never enters the engine.
  assign go_busy = (ALUSel == OP_MULT || ALUSel == OP_MULTU || is_div) && !(is_div && ALUIN2 == '0);
  alu_muldiv_seq #(.WL(WL)) u_muldiv (
    .clk(CLK), .rst_n(RST_N), .start(accept && go_busy), .is_div(is_div),
    .is_signed(ALUSel == OP_MULT || ALUSel == OP_DIV), .op_a(ALUIN1), .op_b(ALUIN2),
    .done(md_done), .res_lo(md_lo), .res_hi(md_hi), .ovf(md_ovf)
  );
`else
  assign go_busy = 1'b0;
  assign md_done = 1'b0;
  assign md_lo = '0;
  assign md_hi = '0;
  assign md_ovf = 1'b0;
`endif
  always_comb begin
    sum = ALUIN1 + ALUIN2;
    dif = ALUIN1 - ALUIN2;
    sc_lo = '0;
    sc_hi = '0;
    sc_flags = '0;
    case (ALUSel)
      OP_ADD: begin
        sc_lo = sum;
        sc_flags.ovf = ALUIN1[WL-1] == ALUIN2[WL-1] && sum[WL-1] != ALUIN1[WL-1];
      end
      OP_SUB: begin
        sc_lo = dif;
        sc_flags.ovf = ALUIN1[WL-1] != ALUIN2[WL-1] && dif[WL-1] != ALUIN1[WL-1];
      end
      OP_LSL:  sc_lo = ALUIN2 << shamt;
      OP_LSR:  sc_lo = ALUIN2 >> shamt;
      OP_LSVL: sc_lo = ALUIN2 << ALUIN1[SHW-1:0];
      OP_LSVR: sc_lo = ALUIN2 >> ALUIN1[SHW-1:0];
      OP_ASVR: sc_lo = $signed(ALUIN2) >>> ALUIN1[SHW-1:0];
      OP_AND:  sc_lo = ALUIN1 & ALUIN2;
      OP_OR:   sc_lo = ALUIN1 | ALUIN2;
      OP_XOR:  sc_lo = ALUIN1 ^ ALUIN2;
      OP_XNOR: sc_lo = ~(ALUIN1 ^ ALUIN2);
      OP_SLT:  sc_lo = {{(WL-1){1'b0}}, $signed(ALUIN1) < $signed(ALUIN2)};
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
`ifdef ALU_MULDIV_EN
        // Only a divide by zero completes here; other mul/div results come from the engine.
        sc_lo = '1;
        sc_hi = ALUIN1;
        sc_flags.div0 = 1'b1;
`else
        sc_flags.ill = 1'b1;
`endif
      end
    endcase
  end
  assign IN_READY = state_q == ST_IDLE || (state_q == ST_DONE && OUT_READY);
  assign accept = IN_VALID && IN_READY;
  assign ld_sc = accept && !go_busy;
  assign ld_md = state_q == ST_BUSY && md_done;
  always_comb begin
    state_d = accept ? (go_busy ? ST_BUSY : ST_DONE)
            : ld_md ? ST_DONE
            : (state_q == ST_DONE && OUT_READY) ? ST_IDLE : state_q;
    lo_d = ld_sc ? sc_lo : ld_md ? md_lo : lo_q;
    hi_d = ld_sc ? sc_hi : ld_md ? md_hi : hi_q;
    flags_d = ld_sc ? sc_flags : ld_md ? alu_flags_t'{ovf: md_ovf, default: 1'b0} : flags_q;
    // An illegal op reports zero=0 even though its result word is 0.
    zero_d = (ld_sc || ld_md) ? (lo_d == '0 && !flags_d.ill) : zero_q;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      lo_q <= '0;
      hi_q <= '0;
      zero_q <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      zero_q <= zero_d;
      flags_q <= flags_d;
    end
  end
  assign OUT_VALID = state_q == ST_DONE;
  assign ALUOut = lo_q;
  assign ALUOutHi = hi_q;
  assign zero = zero_q;
  assign OVF_F = flags_q.ovf;
  assign ILL_F = flags_q.ill;
  assign DIV0_F = flags_q.div0;
endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised successor to the single-cycle datapath ALU. It is a valid/ready-handshaked execute unit. Single-cycle operations have registered results. Signed and unsigned multiply and divide run on an iterative engine. It sits in the execute stage of the multi-cycle/pipelined core and stalls the issuing stage through `IN_READY`.

## Interface
- `WL`, 32: data word length (≥ 8, power of two).
- `SHW`, `$clog2(WL)`: shift-amount width.
- `CLK` in 1: clock; all state updates on rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `IN_VALID` in 1: operation request.
- `IN_READY` out 1: unit can accept; transfer when `IN_VALID && IN_READY`.
- `ALUSel` in 4: opcode.
- `shamt` in SHW: immediate shift amount.
- `ALUIN1`, `ALUIN2` in WL: operands (signed view where the op is signed).
- `OUT_VALID` out 1: result registers hold a result.
- `OUT_READY` in 1: consumer takes result; transfer when `OUT_VALID && OUT_READY`.
- `ALUOut` out WL: result, product low word, or quotient.
- `ALUOutHi` out WL: product high word or remainder; 0 for other ops.
- `zero` out 1: `ALUOut == 0`.
- `OVF_F` out 1: signed overflow.
- `ILL_F` out 1: opcode not implemented.
- `DIV0_F` out 1: divide by zero.

## Operation
- Opcodes:
  - 0000 ADD, 0001 SUB.
  - 0010 LSL `ALUIN2<<shamt`, 0011 LSR.
  - 0100 LSVL, 0101 LSVR, 0110 ASVR. Variable shifts use `ALUIN1[SHW-1:0]` only.
  - 0111 AND, 1000 OR, 1001 XOR, 1010 XNOR.
  - 1011 SLT: signed, result 1 or 0.
  - 1100 MULT, 1101 MULTU: 2·WL product; Hi goes to `ALUOutHi`, Lo to `ALUOut`.
  - 1110 DIV, 1111 DIVU: quotient to `ALUOut`, remainder to `ALUOutHi`. Signed division truncates toward zero; the remainder takes the dividend's sign.
- Overflow rules:
  - ADD: `OVF_F` = operand signs equal and result sign differs.
  - SUB: `OVF_F` = operand signs differ and result sign ≠ sign of `ALUIN1`.
  - DIV of most-negative by −1: quotient = most-negative, remainder 0, `OVF_F`=1.
  - All other ops: `OVF_F`=0.
- Divide by zero (DIV/DIVU, `ALUIN2`==0): quotient all-ones, remainder = `ALUIN1`, `DIV0_F`=1.
- Outputs are never X. An illegal op gives `ALUOut`=`ALUOutHi`=0, `ILL_F`=1, `zero`=0, `OVF_F`=0.
- FSM states are IDLE, BUSY, DONE.
  - IDLE, accept single-cycle op, divide-by-zero, or illegal op → DONE.
  - IDLE, accept mul/div → BUSY. Operands are latched and the counter is loaded with WL.
  - BUSY: one shift-add or restoring-subtract step per cycle. When the counter reaches 0, apply sign fix-up → DONE.
  - DONE with `OUT_READY`: → IDLE, or straight to the next op if a new request is accepted in the same cycle.
- `IN_READY` = IDLE, or (DONE && `OUT_READY`). This allows back-to-back single-cycle ops at full rate.
- Result and flag registers stay stable while `OUT_VALID && !OUT_READY`. Inputs are ignored while `IN_READY`=0.

## Timing
- Reset values:
  - State IDLE.
  - `OUT_VALID`, `ALUOut`, `ALUOutHi`, `zero`, `OVF_F`, `ILL_F`, `DIV0_F` all 0.
  - `IN_READY`=1 from the first cycle after reset release.
- Latency:
  - Single-cycle, divide-by-zero, and illegal ops: `OUT_VALID` in the cycle after acceptance.
  - Mul/div: `OUT_VALID` WL+1 cycles after acceptance.
- Throughput: 1 op/cycle for single-cycle ops with `OUT_READY` held high. One mul/div per WL+2 cycles.
- Reset asserted mid-operation aborts the op. The partial result is discarded and no `OUT_VALID` is produced.

## Configuration
- `ALU_MULDIV_EN` defined: iterative engine present; opcodes 1100–1111 behave as above.
- Not defined: engine and BUSY path removed. Opcodes 1100–1111 complete in 1 cycle as illegal (`ILL_F`=1, results 0). `ALUOutHi` is tied to 0.

## Structure
- Package `alu_pkg` holds:
  - opcode localparams (`OP_ADD` … `OP_DIVU`);
  - FSM state enum (`ST_IDLE`, `ST_BUSY`, `ST_DONE`);
  - the shared flag bundle typedef.
- Sub-module `alu_muldiv_seq`:
  - contains the iterative multiply/divide engine, including sign handling, counter, and start/done pulse;
  - instantiated only under `ALU_MULDIV_EN`.

## Test plan
- Reset sequence:
  - Assert `RST_N`=0 mid-MULT → all outputs 0, `OUT_VALID`=0.
  - Release → `IN_READY`=1.
- ADD 0x7FFFFFFF + 1 → `ALUOut`=0x80000000, `OVF_F`=1, `OUT_VALID` 1 cycle later. Also: SUB 0 − 0 → `zero`=1.
- Back-to-back XOR, ASVR (`ALUIN2`=0x80000000, `ALUIN1`=0x24 → shift 4 → 0xF8000000), SLT(−1, 1)=1, with `OUT_READY`=1 → three results on three consecutive cycles.
- MULT −3 × 5 → `ALUOutHi`=0xFFFFFFFF, `ALUOut`=0xFFFFFFF1, after 33 cycles. Also: hold `OUT_READY`=0 for 4 cycles → outputs stable, `IN_READY`=0.
- Divide cases:
  - DIV −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - DIVU 7 / 0 → `DIV0_F`=1, quotient 0xFFFFFFFF, remainder 7, after 1 cycle.
  - DIV 0x80000000 / −1 → `OVF_F`=1.
- Build without `ALU_MULDIV_EN`: opcode 1100 → `ILL_F`=1, results 0, after 1 cycle.
